// File: rtl/uart_frame_gen.sv
// UART frame generator: transmit FIFO feeding a serializer that emits start,
// data, optional parity and one or two stop bits at a programmable bit rate.
module uart_frame_gen #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wr_en_i,
  input  logic [DATA_WIDTH-1:0]        wr_data_i,
  input  logic                         par_en_i,
  input  logic                         par_typ_i,
  input  logic                         stop2_i,
  input  logic                         msb_first_i,
  input  logic [PRESCALE_W-1:0]        prescale_i,
  output logic                         tx_out_o,
  output logic                         busy_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         ovf_o,
  output logic                         frame_done_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, empty_q, ovf_q;

  logic [2:0]            state_q, state_d;
  logic [PRESCALE_W-1:0] cyc_q, cyc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q, par_typ_q, stop2_q, msb_q;
  logic [PRESCALE_W-1:0] presc_q;
  logic                  tx_out_q, tx_out_d;
  logic                  busy_q, frame_done_q, frame_done_d;

  logic                  push, pop, bit_end;
  logic [PRESCALE_W-1:0] presc_eff;
  logic [IDX_W-1:0]      sel;

  assign push      = wr_en_i & ~full_q & ~rst_i;
  assign presc_eff = (prescale_i == '0) ? PRESCALE_W'(1) : prescale_i;
  assign bit_end   = (cyc_q == presc_q - PRESCALE_W'(1));
  assign count_d   = count_q + CNT_W'(push) - CNT_W'(pop);

  // Next-state, bit timing and registered-output precompute
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    idx_d        = idx_q;
    pop          = 1'b0;
    tx_out_d     = 1'b1;
    frame_done_d = 1'b0;
    sel          = '0;
    case (state_q)
      S_IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          state_d = S_START;
          cyc_d   = '0;
          idx_d   = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cyc_d   = '0;
          idx_d   = '0;
        end else begin
          cyc_d = cyc_q + PRESCALE_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cyc_d = '0;
          if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            idx_d   = '0;
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cyc_d = cyc_q + PRESCALE_W'(1);
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          cyc_d   = '0;
          idx_d   = '0;
        end else begin
          cyc_d = cyc_q + PRESCALE_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cyc_d = '0;
          if (idx_q == IDX_W'(stop2_q)) begin
            idx_d = '0;
            // Chain straight into the next start bit when more data is queued
            if (!empty_q) begin
              pop     = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cyc_d = cyc_q + PRESCALE_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = '0;
        idx_d   = '0;
      end
    endcase

    sel = msb_q ? (IDX_W'(DATA_WIDTH - 1) - idx_d) : idx_d;
    case (state_d)
      S_START:  tx_out_d = 1'b0;
      S_DATA:   tx_out_d = data_q[sel];
      S_PARITY: tx_out_d = (^data_q) ^ par_typ_q;
      default:  tx_out_d = 1'b1;
    endcase

    frame_done_d = (state_d == S_STOP) && (idx_d == IDX_W'(stop2_q)) &&
                   (cyc_d == presc_q - PRESCALE_W'(1));
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cyc_q        <= '0;
      idx_q        <= '0;
      tx_out_q     <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      data_q       <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      stop2_q      <= 1'b0;
      msb_q        <= 1'b0;
      presc_q      <= PRESCALE_W'(1);
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      idx_q        <= idx_d;
      tx_out_q     <= tx_out_d;
      busy_q       <= (state_d != S_IDLE);
      frame_done_q <= frame_done_d;
      ovf_q        <= wr_en_i & full_q;
      count_q      <= count_d;
      full_q       <= (count_d == CNT_W'(DEPTH));
      empty_q      <= (count_d == '0);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      // Frame configuration is frozen at pop time
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
        data_q    <= mem_q[rd_ptr_q];
        par_en_q  <= par_en_i;
        par_typ_q <= par_typ_i;
        stop2_q   <= stop2_i;
        msb_q     <= msb_first_i;
        presc_q   <= presc_eff;
      end
    end
  end

  assign tx_out_o     = tx_out_q;
  assign busy_o       = busy_q;
  assign full_o       = full_q;
  assign empty_o      = empty_q;
  assign count_o      = count_q;
  assign ovf_o        = ovf_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_uart_frame_gen.sv
// Directed bench for uart_frame_gen: table of single-frame vectors plus
// hand-written FIFO burst, overflow and mid-frame reset sequences.
module tb_uart_frame_gen;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       wr_en_i = 1'b0;
  logic [7:0] wr_data_i = '0;
  logic       par_en_i = 1'b0, par_typ_i = 1'b0, stop2_i = 1'b0, msb_first_i = 1'b0;
  logic [5:0] prescale_i = 6'd1;
  logic       tx_out_o, busy_o, full_o, empty_o, ovf_o, frame_done_o;
  logic [2:0] count_o;

  int n_checks = 0;
  int n_errors = 0;

  bit mon_en = 1'b0;
  bit q_tx[$], q_busy[$], q_fd[$], q_ovf[$];

  typedef struct {
    logic [7:0]  data;
    logic        par_en, par_typ, stop2, msb;
    logic [5:0]  prescale;
    int          p_eff;
    logic [11:0] exp_pat;
    int          exp_len;
  } vec_t;

  vec_t vecs [6];

  uart_frame_gen #(.DATA_WIDTH(8), .DEPTH(4), .PRESCALE_W(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
    .par_en_i(par_en_i), .par_typ_i(par_typ_i), .stop2_i(stop2_i),
    .msb_first_i(msb_first_i), .prescale_i(prescale_i), .tx_out_o(tx_out_o),
    .busy_o(busy_o), .full_o(full_o), .empty_o(empty_o), .count_o(count_o),
    .ovf_o(ovf_o), .frame_done_o(frame_done_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (mon_en) begin
      q_tx.push_back(tx_out_o);
      q_busy.push_back(busy_o);
      q_fd.push_back(frame_done_o);
      q_ovf.push_back(ovf_o);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    q_tx.delete(); q_busy.delete(); q_fd.delete(); q_ovf.delete();
  endtask

  task automatic wait_busy(input int budget, output bit ok);
    int n = 0;
    while (!busy_o && n < budget) begin tick(); n++; end
    ok = busy_o;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n = 0;
    while (busy_o && n < budget) begin tick(); n++; end
    ok = !busy_o;
  endtask

  function automatic int first_busy();
    for (int i = 0; i < q_busy.size(); i++) if (q_busy[i]) return i;
    return -1;
  endfunction

  function automatic int count_q_bits(input int which);
    int c = 0;
    for (int i = 0; i < q_fd.size(); i++) c += (which == 0) ? int'(q_fd[i]) : int'(q_ovf[i]);
    return c;
  endfunction

  // Bit pattern sampled at each bit start, busy length, frame_done placement
  task automatic analyze(input int p, output logic [11:0] pat, output int len,
                         output int fd_pos, output bit stable);
    int s = first_busy();
    pat = '0; len = 0; fd_pos = -1; stable = 1'b1;
    if (s >= 0) begin
      for (int i = s; i < q_busy.size() && q_busy[i]; i++) begin
        if (((i - s) % p) == 0) pat = {pat[10:0], q_tx[i]};
        else if (q_tx[i] != q_tx[i-1]) stable = 1'b0;
        if (q_fd[i]) fd_pos = i - s;
        len++;
      end
    end
  endtask

  // Decode frame f of a back-to-back run at one cycle per bit, 10-bit frames
  function automatic int decode(input int s, input int f);
    logic [7:0] w = '0;
    for (int k = 0; k < 8; k++) begin
      int idx = s + 10 * f + 1 + k;
      if (idx < q_tx.size()) w[k] = q_tx[idx];
    end
    return int'(w);
  endfunction

  task automatic run_vector(input vec_t v, input int id);
    logic [11:0] pat;
    int len, fd_pos;
    bit stable, ok1, ok2;
    par_en_i = v.par_en; par_typ_i = v.par_typ; stop2_i = v.stop2;
    msb_first_i = v.msb; prescale_i = v.prescale;
    clear_mon();
    mon_en = 1'b1;
    wr_en_i = 1'b1; wr_data_i = v.data;
    tick();
    wr_en_i = 1'b0;
    wait_busy(20, ok1);
    ok2 = 1'b0;
    if (ok1) begin
      tick(); tick();
      // Disturb every configuration input while the frame is in flight
      par_en_i = ~v.par_en; par_typ_i = ~v.par_typ; stop2_i = ~v.stop2;
      msb_first_i = ~v.msb; prescale_i = v.prescale + 6'd3;
      wait_idle(2000, ok2);
    end
    tick();
    mon_en = 1'b0;
    check($sformatf("v%0d_frame_timeout", id), int'(ok1 && ok2), 1);
    analyze(v.p_eff, pat, len, fd_pos, stable);
    check($sformatf("v%0d_line_pattern", id), int'(pat), int'(v.exp_pat));
    check($sformatf("v%0d_busy_len", id), len, v.exp_len);
    check($sformatf("v%0d_frame_done_cnt", id), count_q_bits(0), 1);
    check($sformatf("v%0d_frame_done_pos", id), fd_pos, v.exp_len - 1);
    check($sformatf("v%0d_bit_stable", id), int'(stable), 1);
  endtask

  task automatic burst(input int nwr, input logic [7:0] w0, input logic [7:0] w1,
                       input logic [7:0] w2, input logic [7:0] w3,
                       input logic [7:0] w4, input logic [7:0] w5, input string tag);
    logic [7:0] ws [6];
    bit ok;
    int s, run;
    ws = '{w0, w1, w2, w3, w4, w5};
    par_en_i = 1'b0; stop2_i = 1'b0; msb_first_i = 1'b0; prescale_i = 6'd1;
    clear_mon();
    mon_en = 1'b1;
    for (int i = 0; i < nwr; i++) begin
      wr_en_i = 1'b1; wr_data_i = ws[i];
      tick();
    end
    wr_en_i = 1'b0;
    check({tag, "_count_after_writes"}, int'(count_o), 4);
    check({tag, "_full_after_writes"}, int'(full_o), 1);
    wait_idle(500, ok);
    tick(); tick();
    mon_en = 1'b0;
    check({tag, "_timeout"}, int'(ok), 1);
    s = first_busy();
    run = 0;
    if (s >= 0) for (int i = s; i < q_busy.size() && q_busy[i]; i++) run++;
    check({tag, "_busy_run"}, run, 50);
    check({tag, "_frame_done_cnt"}, count_q_bits(0), 5);
    check({tag, "_ovf_cnt"}, count_q_bits(1), nwr - 5);
    for (int f = 0; f < 5; f++)
      check($sformatf("%s_word%0d", tag, f), decode(s, f), int'(ws[f]));
  endtask

  initial begin
    bit ok;
    //          data   pe    pt    s2    msb   presc  p  pattern       len
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 6'd8, 8, 12'h295, 88};
    vecs[1] = '{8'h0E, 1'b1, 1'b1, 1'b0, 1'b1, 6'd4, 4, 12'h039, 44};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1, 12'h0F3, 11};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 6'd2, 2, 12'h00B, 24};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 6'd3, 3, 12'h1FF, 30};
    vecs[5] = '{8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 6'd1, 1, 12'h007, 11};

    rst_i = 1'b1;
    tick(); tick(); tick();
    check("rst_tx", int'(tx_out_o), 1);
    check("rst_busy", int'(busy_o), 0);
    check("rst_empty", int'(empty_o), 1);
    check("rst_full", int'(full_o), 0);
    check("rst_count", int'(count_o), 0);
    check("rst_ovf", int'(ovf_o), 0);
    check("rst_frame_done", int'(frame_done_o), 0);
    rst_i = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vector(vecs[i], i);

    burst(5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00, "burst5");
    burst(6, 8'hC3, 8'h5A, 8'h0F, 8'hF0, 8'h96, 8'h69, "burst6");

    // Reset during the third data bit of a 4-cycle-per-bit frame
    par_en_i = 1'b0; stop2_i = 1'b0; msb_first_i = 1'b0; prescale_i = 6'd4;
    clear_mon();
    mon_en = 1'b1;
    wr_en_i = 1'b1; wr_data_i = 8'h5A;
    tick();
    wr_en_i = 1'b0;
    wait_busy(20, ok);
    check("rstmid_start_timeout", int'(ok), 1);
    for (int i = 0; i < 13; i++) tick();
    check("rstmid_pre_tx", int'(tx_out_o), 0);
    check("rstmid_pre_busy", int'(busy_o), 1);
    rst_i = 1'b1; wr_en_i = 1'b1; wr_data_i = 8'h77;
    tick();
    check("rstmid_tx", int'(tx_out_o), 1);
    check("rstmid_busy", int'(busy_o), 0);
    check("rstmid_count", int'(count_o), 0);
    check("rstmid_empty", int'(empty_o), 1);
    tick();
    rst_i = 1'b0; wr_en_i = 1'b0;
    tick(); tick(); tick();
    check("rstmid_write_ignored", int'(count_o), 0);
    check("rstmid_idle_busy", int'(busy_o), 0);
    mon_en = 1'b0;
    check("rstmid_no_frame_done", count_q_bits(0), 0);
    run_vector(vecs[2], 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
